// File: rtl/serial_frame_controller.sv
// serial_frame_controller
//
// Receives a bit-serial frame, one bit per clkEn strobe:
//   start bit (0), 2-bit destination port (MSB first), 4-bit payload
//   length (MSB first), then `length` payload bits.
// Each payload bit is re-registered onto serOut with a one-cycle
// serOutValid pulse, steered to outValid[port]. A one-cycle done pulse
// closes every frame, including zero-length frames.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   clkEn        one-cycle bit strobe; serIn is only sampled when high
//   serIn        serial frame input
//   serOut       registered copy of the current payload bit
//   serOutValid  one-cycle pulse, serOut valid
//   outValid     one-hot per-port copy of serOutValid
//   port         latched destination port
//   remaining    payload bits still to send
//   state        FSM state code
//   done         one-cycle frame-complete pulse
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | 0: wait for a start bit (serIn=0 on a strobe)
// PORT  | 1: shift in the 2 port bits
// LEN   | 2: shift in the 4 length bits, then load remaining
// XMIT  | 3: forward payload bits until remaining reaches 0
// DONE  | 4: one-cycle done pulse, then back to IDLE unconditionally

module serial_frame_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic       clkEn,
  input  logic       serIn,
  output logic       serOut,
  output logic       serOutValid,
  output logic [3:0] outValid,
  output logic [1:0] port,
  output logic [3:0] remaining,
  output logic [2:0] state,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PORT = 3'd1,
    S_LEN  = 3'd2,
    S_XMIT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t     state_q;
  state_t     state_d;

  logic [1:0] bit_cnt_q;
  logic [1:0] port_q;
  logic [3:0] length_q;
  logic [3:0] remaining_q;
  logic       serout_q;
  logic       serout_valid_q;

  logic       start_bit;
  logic       shift_port;
  logic       shift_len;
  logic       load_rem;
  logic       xmit_bit;
  logic [3:0] len_next;

  // Length as it will be once the current serIn bit is shifted in; used
  // on the last LEN strobe so remaining and the exit decision see the
  // complete value in the same edge.
  assign len_next = {length_q[2:0], serIn};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath strobes
  always_comb begin
    state_d    = state_q;
    start_bit  = 1'b0;
    shift_port = 1'b0;
    shift_len  = 1'b0;
    load_rem   = 1'b0;
    xmit_bit   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (clkEn && !serIn) begin
          start_bit = 1'b1;
          state_d   = S_PORT;
        end
      end

      S_PORT: begin
        if (clkEn) begin
          shift_port = 1'b1;
          if (bit_cnt_q == 2'd1) begin
            state_d = S_LEN;
          end
        end
      end

      S_LEN: begin
        if (clkEn) begin
          shift_len = 1'b1;
          if (bit_cnt_q == 2'd3) begin
            load_rem = 1'b1;
            state_d  = (len_next == 4'd0) ? S_DONE : S_XMIT;
          end
        end
      end

      S_XMIT: begin
        if (clkEn) begin
          xmit_bit = 1'b1;
          // remaining==0 cannot normally be seen here; treat it as the
          // last bit so the FSM can never stall in XMIT.
          if (remaining_q <= 4'd1) begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q      <= 2'd0;
      port_q         <= 2'd0;
      length_q       <= 4'd0;
      remaining_q    <= 4'd0;
      serout_q       <= 1'b0;
      serout_valid_q <= 1'b0;
    end else begin
      serout_valid_q <= xmit_bit;

      if (start_bit) begin
        bit_cnt_q <= 2'd0;
        port_q    <= 2'd0;
        length_q  <= 4'd0;
      end

      if (shift_port) begin
        port_q    <= {port_q[0], serIn};
        bit_cnt_q <= (bit_cnt_q == 2'd1) ? 2'd0 : bit_cnt_q + 2'd1;
      end

      // 2-bit counter wraps 3->0 on the last length bit, leaving it
      // cleared for the next frame.
      if (shift_len) begin
        length_q  <= len_next;
        bit_cnt_q <= bit_cnt_q + 2'd1;
      end

      if (load_rem) begin
        remaining_q <= len_next;
      end

      if (xmit_bit) begin
        serout_q <= serIn;
        if (remaining_q != 4'd0) begin
          remaining_q <= remaining_q - 4'd1;
        end
      end
    end
  end

  // Outputs
  always_comb begin
    outValid = 4'b0000;
    if (serout_valid_q) begin
      outValid = 4'b0001 << port_q;
    end
  end

  assign serOut      = serout_q;
  assign serOutValid = serout_valid_q;
  assign port        = port_q;
  assign remaining   = remaining_q;
  assign state       = state_q;
  assign done        = (state_q == S_DONE);

endmodule

// File: tb/tb_serial_frame_controller.sv
module tb_serial_frame_controller;

  logic       clk;
  logic       rst;
  logic       clkEn;
  logic       serIn;
  logic       serOut;
  logic       serOutValid;
  logic [3:0] outValid;
  logic [1:0] port;
  logic [3:0] remaining;
  logic [2:0] state;
  logic       done;

  serial_frame_controller dut (
    .clk         (clk),
    .rst         (rst),
    .clkEn       (clkEn),
    .serIn       (serIn),
    .serOut      (serOut),
    .serOutValid (serOutValid),
    .outValid    (outValid),
    .port        (port),
    .remaining   (remaining),
    .state       (state),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Observed payload pulses and done pulses, appended by the monitor only.
  typedef struct packed {
    logic       so;
    logic [3:0] ov;
    logic [3:0] rem;
  } obs_t;

  obs_t obs[$];
  int   done_cnt = 0;
  int   viol     = 0;

  always @(negedge clk) begin
    if (serOutValid) obs.push_back('{serOut, outValid, remaining});
    if (done) done_cnt++;
    if (!serOutValid && outValid != 4'b0000) viol++;
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic strobe(input logic b);
    clkEn = 1'b1;
    serIn = b;
    @(posedge clk);
    #1;
    clkEn = 1'b0;
    serIn = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Start bit, port MSB first, length MSB first.
  task automatic send_header(input logic [1:0] p, input logic [3:0] len, input int gap);
    strobe(1'b0);
    for (int i = 1; i >= 0; i--) begin
      idle_cycles(gap);
      strobe(p[i]);
    end
    for (int i = 3; i >= 0; i--) begin
      idle_cycles(gap);
      strobe(len[i]);
    end
  endtask

  // Compare everything recorded since the bases against the frame model:
  // pulse i carries data[i] on port p with (len-1-i) bits still to go.
  task automatic check_tail(input string nm, input logic [1:0] p, input int exp_pulses,
                            input logic [14:0] data, input logic [3:0] exp_onehot,
                            input int ob, input int db);
    int n;
    n = obs.size() - ob;
    chk({nm, ".pulses"}, n, exp_pulses);
    for (int i = 0; i < exp_pulses; i++) begin
      if (i < n) begin
        chk({nm, ".serOut"}, int'(obs[ob+i].so), int'(data[i]));
        chk({nm, ".outValid"}, int'(obs[ob+i].ov), int'(exp_onehot));
        chk({nm, ".remaining"}, int'(obs[ob+i].rem), exp_pulses - 1 - i);
      end
    end
    chk({nm, ".done_pulses"}, done_cnt - db, 1);
    chk({nm, ".state_idle"}, int'(state), 0);
    chk({nm, ".port_held"}, int'(port), int'(p));
    chk({nm, ".remaining_idle"}, int'(remaining), 0);
    chk({nm, ".ov_quiet"}, viol, 0);
  endtask

  task automatic run_frame(input string nm, input logic [1:0] p, input logic [3:0] len,
                           input logic [14:0] data, input int gap,
                           input logic [3:0] exp_onehot, input int exp_hdr_state,
                           input int exp_pulses);
    int ob;
    int db;
    ob = obs.size();
    db = done_cnt;
    send_header(p, len, gap);
    chk({nm, ".hdr_state"}, int'(state), exp_hdr_state);
    chk({nm, ".hdr_remaining"}, int'(remaining), int'(len));
    for (int i = 0; i < int'(len); i++) begin
      idle_cycles(gap);
      strobe(data[i]);
    end
    idle_cycles(3);
    check_tail(nm, p, exp_pulses, data, exp_onehot, ob, db);
  endtask

  typedef struct {
    logic [1:0]  p;
    logic [3:0]  len;
    logic [14:0] data;
    int          gap;
    logic [3:0]  exp_onehot;
    int          exp_hdr_state;
    int          exp_pulses;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int ob;
    int db;
    logic [1:0]  rp;
    logic [3:0]  rl;
    logic [14:0] rd;

    vecs[0] = '{2'd2, 4'd3,  15'b000_0000_0000_0101, 0, 4'b0100, 3, 3};
    vecs[1] = '{2'd0, 4'd0,  15'b000_0000_0000_0000, 0, 4'b0001, 4, 0};
    vecs[2] = '{2'd3, 4'd15, 15'b101_0101_0101_0101, 1, 4'b1000, 3, 15};
    vecs[3] = '{2'd1, 4'd1,  15'b000_0000_0000_0001, 2, 4'b0010, 3, 1};
    vecs[4] = '{2'd2, 4'd8,  15'b000_0000_1001_0110, 0, 4'b0100, 3, 8};

    rst   = 1'b1;
    clkEn = 1'b1;
    serIn = 1'b0;
    idle_cycles(2);
    rst   = 1'b0;
    clkEn = 1'b0;
    serIn = 1'b1;

    chk("rst.state", int'(state), 0);
    chk("rst.port", int'(port), 0);
    chk("rst.remaining", int'(remaining), 0);
    chk("rst.serOut", int'(serOut), 0);
    chk("rst.serOutValid", int'(serOutValid), 0);
    chk("rst.outValid", int'(outValid), 0);
    chk("rst.done", int'(done), 0);

    foreach (vecs[k]) begin
      run_frame($sformatf("vec%0d", k), vecs[k].p, vecs[k].len, vecs[k].data, vecs[k].gap,
                vecs[k].exp_onehot, vecs[k].exp_hdr_state, vecs[k].exp_pulses);
    end

    // Idle ones are not start bits.
    ob = obs.size();
    db = done_cnt;
    for (int i = 0; i < 5; i++) begin
      strobe(1'b1);
      chk("idle_ones.state", int'(state), 0);
    end
    idle_cycles(2);
    chk("idle_ones.pulses", obs.size() - ob, 0);
    chk("idle_ones.done", done_cnt - db, 0);

    // Reset mid-XMIT with clkEn also high: reset wins, frame discarded.
    send_header(2'd1, 4'd3, 0);
    strobe(1'b1);
    rst   = 1'b1;
    clkEn = 1'b1;
    serIn = 1'b0;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    clkEn = 1'b0;
    serIn = 1'b1;
    chk("midrst.state", int'(state), 0);
    chk("midrst.port", int'(port), 0);
    chk("midrst.remaining", int'(remaining), 0);
    chk("midrst.serOut", int'(serOut), 0);
    chk("midrst.serOutValid", int'(serOutValid), 0);
    chk("midrst.outValid", int'(outValid), 0);
    chk("midrst.done", int'(done), 0);
    idle_cycles(1);
    run_frame("after_rst", 2'd1, 4'd3, 15'b000_0000_0000_0110, 0, 4'b0010, 3, 3);

    // clkEn low for 20 cycles halfway through LEN.
    ob = obs.size();
    db = done_cnt;
    strobe(1'b0);
    strobe(1'b1);
    strobe(1'b0);
    strobe(1'b1);
    strobe(1'b0);
    idle_cycles(20);
    chk("stall.state", int'(state), 2);
    chk("stall.port", int'(port), 2);
    chk("stall.remaining", int'(remaining), 0);
    chk("stall.pulses", obs.size() - ob, 0);
    strobe(1'b1);
    strobe(1'b0);
    chk("stall.hdr_state", int'(state), 3);
    chk("stall.hdr_remaining", int'(remaining), 10);
    for (int i = 0; i < 10; i++) strobe(logic'((13'h0b5a >> i) & 1));
    idle_cycles(3);
    check_tail("stall", 2'd2, 10, 15'h0b5a & 15'h03ff, 4'b0100, ob, db);

    // clkEn held high through DONE with serIn=0 must not start a frame.
    ob = obs.size();
    db = done_cnt;
    send_header(2'd0, 4'd1, 0);
    clkEn = 1'b1;
    serIn = 1'b1;
    @(posedge clk);
    #1;
    serIn = 1'b0;
    chk("done_ign.state_done", int'(state), 4);
    @(posedge clk);
    #1;
    clkEn = 1'b0;
    serIn = 1'b1;
    chk("done_ign.state", int'(state), 0);
    idle_cycles(2);
    check_tail("done_ign", 2'd0, 1, 15'b1, 4'b0001, ob, db);

    // Randomised frames against the frame-level model.
    for (int f = 0; f < 30; f++) begin
      int nones;
      int gap;
      rp    = 2'($urandom_range(0, 3));
      rl    = 4'($urandom_range(0, 15));
      rd    = 15'($urandom);
      gap   = $urandom_range(0, 2);
      nones = $urandom_range(0, 2);
      for (int i = 0; i < nones; i++) strobe(1'b1);
      run_frame($sformatf("rand%0d", f), rp, rl, rd, gap, 4'b0001 << rp,
                (rl == 4'd0) ? 4 : 3, int'(rl));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
